gain_multiplier_seq: RTL and testbench
======================================

Name: gain_multiplier_seq

Overview:
Iterative shift-add signed multiplier that applies a fixed-point gain to one audio sample at a time. It sits between the ADC sample path and the memory/delay controller, replacing the single-cycle unrolled gain multiply. It adds parametrised widths, rounding, output saturation, a bypass mode and valid/ready handshakes on both sides.

Parameters:
DATA_W, 16, sample width; two's-complement signed.
GAIN_W, 16, gain width; two's-complement signed; sets the number of iteration cycles.
FRAC_BITS, 8, fractional bits of the gain (Q(GAIN_W-FRAC_BITS).FRAC_BITS); range 0..GAIN_W-1.

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input sample and gain valid
in_ready  out  1  block can accept an input
data_in  in  DATA_W  signed sample
gain  in  GAIN_W  signed fixed-point gain
bypass  in  1  sampled at accept; 1 = pass data_in through unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
data_out  out  DATA_W  rounded, saturated result
out_sat  out  1  result was clipped; qualified by out_valid

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, in_ready=1, out_valid=0, data_out=0, out_sat=0. Any operation in flight is discarded and no output is produced for it.
- States: IDLE, CALC, ROUND, DONE.
- in_ready is 1 only in IDLE. It is combinational from state, not from in_valid.
- IDLE: on in_valid&&in_ready, latch data_in, gain and bypass, clear the accumulator and iteration counter, then go to CALC. With in_valid=0, stay in IDLE. Input values outside the accept edge are ignored.
- CALC: exactly GAIN_W cycles, one gain bit per cycle (LSB first), conditionally adding the shifted sample into a DATA_W+GAIN_W accumulator. The gain MSB carries negative weight, so the product is exact and signed. There is no early exit for zero bits or a zero gain. After the last bit, go to ROUND.
- ROUND, one cycle:
  - If FRAC_BITS>0, add 2^(FRAC_BITS-1), then shift right arithmetically by FRAC_BITS. This is round-half-toward-+inf.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and set out_sat if clipped.
  - If bypass was latched, data_out = latched data_in and out_sat=0.
  - Register data_out, set out_valid=1, go to DONE.
- Latency: out_valid rises exactly GAIN_W+1 clocks after the accepting edge (17 at defaults), regardless of bypass or operand values.
- DONE: data_out, out_sat and out_valid are held stable while out_ready=0. On out_valid&&out_ready, clear out_valid and go to IDLE. in_ready returns next cycle.
- Throughput: one sample per GAIN_W+3 clocks minimum. A new input is never accepted on the same edge as the output handshake.
- out_sat and data_out keep their last values after the handshake; they are qualified only by out_valid.
- Changes on gain, data_in or bypass during CALC, ROUND or DONE have no effect.
- rst asserted simultaneously with any handshake: reset wins.
- Internal accumulator width is DATA_W+GAIN_W. It cannot overflow before saturation; the product of two most-negative operands is representable.

Test Plan:
- Unity gain (defaults): data_in=0x1234, gain=0x0100, bypass=0, out_ready=1 -> data_out=0x1234, out_sat=0, out_valid exactly 17 clocks after accept; in_ready low from accept+1 until after the handshake.
- Positive saturation: data_in=0x4000, gain=0x0200 -> 0x7FFF, out_sat=1. Most-negative case: data_in=0x8000, gain=0xFF00 (-1.0) -> 0x7FFF, out_sat=1.
- Negative saturation and sign: data_in=0xC000, gain=0x0300 -> 0x8000, out_sat=1. data_in=0x0100, gain=0xFF80 (-0.5) -> 0xFF80, out_sat=0.
- Rounding:
  - data_in=0x0003, gain=0x0080 -> 0x0002.
  - data_in=0xFFFD, gain=0x0080 -> 0xFFFF.
  - data_in=0x0001, gain=0x0040 -> 0x0000.
  - All three with out_sat=0.
- Bypass and backpressure: bypass=1, data_in=0x8001, gain=0x7FFF -> data_out=0x8001, out_sat=0, same latency. Hold out_ready=0 for 10 cycles: data_out and out_valid stay stable and in_ready stays 0. Raise out_ready: one handshake, in_ready=1 on the next cycle. Toggling gain and data_in during CALC does not change the result.
- Reset mid-operation: accept a sample, assert rst at CALC cycle 5 -> next cycle in_ready=1, out_valid=0, data_out=0. No stale output appears, and the next accepted sample (0x0010 x 0x0100) yields 0x0010 with normal latency.

Source files
------------

// File: rtl/gain_multiplier_seq.sv
// Iterative shift-add signed gain multiplier with rounding, saturation and bypass.
// Latency GAIN_W+1 clocks accept-to-out_valid; in_ready only in IDLE, result held until out_ready.
module gain_multiplier_seq #(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [GAIN_W-1:0] gain,
  input  logic              bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_sat
);

  localparam int ACC_W = DATA_W + GAIN_W;
  localparam int CNT_W = $clog2(GAIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(GAIN_W - 1);

  // Half an output LSB; collapses to zero when the gain is an integer (FRAC_BITS=0).
  localparam logic signed [ACC_W:0] RND_HALF = $signed(((ACC_W+1)'(1) << FRAC_BITS) >> 1);
  localparam logic signed [ACC_W:0] SAT_MAX  = {{(GAIN_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN  = {{(GAIN_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ROUND,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   mcand_q, mcand_d;
  logic        [GAIN_W-1:0]  gain_q, gain_d;
  logic        [DATA_W-1:0]  data_q, data_d;
  logic                      byp_q, byp_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic        [DATA_W-1:0]  dout_q, dout_d;
  logic                      sat_q, sat_d;
  logic                      oval_q, oval_d;

  logic signed [ACC_W:0]     rnd_sum;
  logic signed [ACC_W:0]     rnd_shr;
  logic        [DATA_W-1:0]  rnd_res;
  logic                      rnd_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      gain_q  <= '0;
      data_q  <= '0;
      byp_q   <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      gain_q  <= gain_d;
      data_q  <= data_d;
      byp_q   <= byp_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
      oval_q  <= oval_d;
    end
  end

  // Round half toward +inf, then clip to the sample range.
  always_comb begin
    rnd_sum = $signed({acc_q[ACC_W-1], acc_q}) + RND_HALF;
    rnd_shr = rnd_sum >>> FRAC_BITS;
    rnd_res = rnd_shr[DATA_W-1:0];
    rnd_sat = 1'b0;
    if (rnd_shr > SAT_MAX) begin
      rnd_res = SAT_MAX[DATA_W-1:0];
      rnd_sat = 1'b1;
    end else if (rnd_shr < SAT_MIN) begin
      rnd_res = SAT_MIN[DATA_W-1:0];
      rnd_sat = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    gain_d  = gain_q;
    data_d  = data_q;
    byp_d   = byp_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    sat_d   = sat_q;
    oval_d  = oval_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d = {{GAIN_W{data_in[DATA_W-1]}}, data_in};
          gain_d  = gain;
          data_d  = data_in;
          byp_d   = bypass;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Gain MSB has negative weight, so the final partial product is subtracted.
        if (gain_q[0]) begin
          if (cnt_q == LAST_BIT) begin
            acc_d = acc_q - mcand_q;
          end else begin
            acc_d = acc_q + mcand_q;
          end
        end
        mcand_d = mcand_q <<< 1;
        gain_d  = gain_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (byp_q) begin
          dout_d = data_q;
          sat_d  = 1'b0;
        end else begin
          dout_d = rnd_res;
          sat_d  = rnd_sat;
        end
        oval_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          oval_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = oval_q;
  assign data_out  = dout_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_gain_multiplier_seq.sv
// Scoreboarded bench for gain_multiplier_seq: directed vectors in, monitor checks results and latency.
module tb_gain_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic [15:0] gain;
  logic        bypass;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic        out_sat;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [16:0] exp_q[$];
  int          t_acc_q[$];

  logic        prev_v  = 1'b0;
  logic [15:0] prev_d  = '0;
  logic        prev_s  = 1'b0;
  logic        hs_prev = 1'b0;

  gain_multiplier_seq #(.DATA_W(16), .GAIN_W(16), .FRAC_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .gain      (gain),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] g, input logic b,
                      input logic [15:0] ed, input logic es, input bit track);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    data_in  = d;
    gain     = g;
    bypass   = b;
    tick();
    in_valid = 1'b0;
    data_in  = 16'($urandom);
    gain     = 16'($urandom);
    bypass   = 1'($urandom);
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    if (track) begin
      exp_q.push_back({es, ed});
      t_acc_q.push_back(cyc);
    end
  endtask

  // Monitor: latency at rise, stability under backpressure, result at handshake.
  always @(negedge clk) begin
    logic        hs;
    logic [16:0] ex;
    hs = 1'b0;
    if (rst) begin
      prev_v  = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("in_ready_after_hs", 32'(in_ready), 32'd1);
      if (out_valid && !prev_v) begin
        if (t_acc_q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          chk("latency", 32'(cyc - t_acc_q.pop_front()), 32'd17);
        end
      end
      if (out_valid && prev_v) begin
        chk("hold_data", 32'(data_out), 32'(prev_d));
        chk("hold_sat", 32'(out_sat), 32'(prev_s));
      end
      if (out_valid) chk("in_ready_while_valid", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        hs = 1'b1;
        if (exp_q.size() == 0) begin
          chk("extra_handshake", 32'(out_valid), 32'd0);
        end else begin
          ex = exp_q.pop_front();
          chk("data_out", 32'(data_out), 32'(ex[15:0]));
          chk("out_sat", 32'(out_sat), 32'(ex[16]));
        end
      end
      prev_v  = out_valid;
      prev_d  = data_out;
      prev_s  = out_sat;
      hs_prev = hs;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    gain      = '0;
    bypass    = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_out_sat", 32'(out_sat), 32'd0);

    send(16'h1234, 16'h0100, 1'b0, 16'h1234, 1'b0, 1'b1);
    send(16'h4000, 16'h0200, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    send(16'h8000, 16'hFF00, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    send(16'hC000, 16'h0300, 1'b0, 16'h8000, 1'b1, 1'b1);
    send(16'h0100, 16'hFF80, 1'b0, 16'hFF80, 1'b0, 1'b1);
    send(16'h0003, 16'h0080, 1'b0, 16'h0002, 1'b0, 1'b1);
    send(16'hFFFD, 16'h0080, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    send(16'h0001, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b1);
    send(16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    send(16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1);

    // Bypass under backpressure with operand churn during CALC.
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    out_ready = 1'b0;
    send(16'h8001, 16'h7FFF, 1'b1, 16'h8001, 1'b0, 1'b1);
    repeat (8) begin
      data_in = 16'($urandom);
      gain    = 16'($urandom);
      bypass  = 1'($urandom);
      tick();
    end
    w = 0;
    while (!out_valid && w < 100) begin
      tick();
      w++;
    end
    chk("bypass_valid_seen", 32'(out_valid), 32'd1);
    repeat (10) tick();
    out_ready = 1'b1;
    tick();

    // Abort an operation with reset during CALC.
    send(16'h5555, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    send(16'h0010, 16'h0100, 1'b0, 16'h0010, 1'b0, 1'b1);

    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
